// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_t : hazard FSM state (RUN = free-flowing, STALL = multi-cycle load stall)
//   FWD_*      : encodings for the EX-stage operand forwarding muxes
//   REG_ZERO   : index of the hard-wired zero register
//   SCNT_W     : width of the remaining-stall counter (covers 1..15 stall cycles)
package pipeline_hazard_controller_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_t;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int REG_ZERO = 0;
  localparam int SCNT_W   = 4;

endpackage

// File: rtl/pipeline_hazard_controller_forward_select.sv
// forward_select: combinational forwarding-source selector for one ALU operand.
// Ports:
//   src            in  source register of the operand in EX
//   exmem_rd       in  destination register held in EX/MEM
//   exmem_regwrite in  EX/MEM instruction writes the register file
//   memwb_rd       in  destination register held in MEM/WB
//   memwb_regwrite in  MEM/WB instruction writes the register file
//   fwd            out 00 = regfile, 10 = EX/MEM result, 01 = MEM/WB result
module forward_select
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_regwrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_regwrite,
  output logic [1:0]            fwd
);

  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

  // EX/MEM is checked first: it holds the younger, and therefore correct, value.
  always_comb begin
    fwd = FWD_RF;
    if (exmem_regwrite && (exmem_rd != ZERO) && (exmem_rd == src)) begin
      fwd = FWD_EXMEM;
    end else if (memwb_regwrite && (memwb_rd != ZERO) && (memwb_rd == src)) begin
      fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: load-use stall, taken-branch flush and operand
// forwarding control for a 5-stage pipeline, plus saturating perf counters.
// Ports:
//   clk, reset                  rising-edge clock, asynchronous active-high reset
//   id_rs1, id_rs2              sources of the instruction in ID
//   idex_rs1, idex_rs2, idex_rd sources/destination of the instruction in EX
//   idex_memread                instruction in EX is a load
//   exmem_rd, exmem_regwrite    destination / write-enable in MEM
//   memwb_rd, memwb_regwrite    destination / write-enable in WB
//   ex_branch_taken             beq in EX resolved taken
//   cnt_clr                     synchronous clear of both perf counters
//   pc_write, ifid_write        PC / IF/ID load enables
//   ifid_flush, idex_bubble     insert NOP into IF/ID / ID/EX
//   fwd_a, fwd_b                ALU operand forwarding selects
//   stall_count, flush_count    saturating stall-cycle / flush-event counters
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int REG_ADDR_W        = 5,
  parameter int LOAD_STALL_CYCLES = 1,  // legal range 1..15
  parameter int CNT_W             = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rs1,
  input  logic [REG_ADDR_W-1:0] idex_rs2,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_regwrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_regwrite,
  input  logic                  ex_branch_taken,
  input  logic                  cnt_clr,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(REG_ZERO);

  hz_state_t         state_reg;
  logic [SCNT_W-1:0] scnt_reg;
  logic [CNT_W-1:0]  stall_count_reg;
  logic [CNT_W-1:0]  flush_count_reg;

  logic       hz;
  logic       flush;
  logic       stall;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;

  // Hazard detection and per-cycle action. Reset is folded in so the outputs
  // show their idle values in the very cycle reset is raised, even while the
  // hazard inputs are still asserted.
  always_comb begin
    hz    = idex_memread && (idex_rd != ZERO) &&
            ((idex_rd == id_rs1) || (idex_rd == id_rs2));
    flush = !reset && ex_branch_taken;
    // Flush beats stall: the stalled instruction is on the wrong path anyway.
    stall = !reset && !ex_branch_taken && ((state_reg == STALL) || hz);
  end

  assign pc_write    = !stall;
  assign ifid_write  = !stall;
  assign ifid_flush  = flush;
  assign idex_bubble = stall || flush;

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .src            (idex_rs1),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .fwd            (fwd_a_sel)
  );

  forward_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .src            (idex_rs2),
    .exmem_rd       (exmem_rd),
    .exmem_regwrite (exmem_regwrite),
    .memwb_rd       (memwb_rd),
    .memwb_regwrite (memwb_regwrite),
    .fwd            (fwd_b_sel)
  );

  assign fwd_a = reset ? FWD_RF : fwd_a_sel;
  assign fwd_b = reset ? FWD_RF : fwd_b_sel;

  // Stall FSM. The first stall cycle is spent in RUN; scnt_reg counts the
  // stall cycles still owed after that one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      scnt_reg  <= '0;
    end else begin
      case (state_reg)
        RUN: begin
          if (!ex_branch_taken && hz && (LOAD_STALL_CYCLES > 1)) begin
            state_reg <= STALL;
            scnt_reg  <= SCNT_W'(LOAD_STALL_CYCLES - 1);
          end
        end
        STALL: begin
          if (ex_branch_taken || (scnt_reg == SCNT_W'(1))) begin
            state_reg <= RUN;
            scnt_reg  <= '0;
          end else begin
            scnt_reg <= scnt_reg - SCNT_W'(1);
          end
        end
        default: begin
          state_reg <= RUN;
          scnt_reg  <= '0;
        end
      endcase
    end
  end

  // Saturating performance counters; a clear overrides any same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else if (cnt_clr) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      if (stall && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
      if (flush && (flush_count_reg != '1)) begin
        flush_count_reg <= flush_count_reg + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd, exmem_rd, memwb_rd;
  logic       idex_memread, exmem_regwrite, memwb_regwrite, ex_branch_taken, cnt_clr;

  // u1: single-cycle stall, narrow counters (saturation reachable quickly)
  logic       pc1, ifw1, fl1, bub1;
  logic [1:0] fa1, fb1;
  logic [3:0] sc1, fc1;
  // u3: three-cycle stall, default counters
  logic        pc3, ifw3, fl3, bub3;
  logic [1:0]  fa3, fb3;
  logic [15:0] sc3, fc3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(4)) u1 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
    .pc_write(pc1), .ifid_write(ifw1), .ifid_flush(fl1), .idex_bubble(bub1),
    .fwd_a(fa1), .fwd_b(fb1), .stall_count(sc1), .flush_count(fc1)
  );

  pipeline_hazard_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_memread(idex_memread),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite),
    .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
    .pc_write(pc3), .ifid_write(ifw3), .ifid_flush(fl3), .idex_bubble(bub3),
    .fwd_a(fa3), .fwd_b(fb3), .stall_count(sc3), .flush_count(fc3)
  );

  typedef struct {
    logic [4:0] id_rs1, id_rs2, idex_rs1, idex_rs2, idex_rd;
    logic       memread;
    logic [4:0] exmem_rd;
    logic       exmem_rw;
    logic [4:0] memwb_rd;
    logic       memwb_rw;
    logic       br;
    logic [7:0] exp;  // {pc_write, ifid_write, ifid_flush, idex_bubble, fwd_a, fwd_b}
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input int e,
                              input int f, input int g, input int h, input int i, input int j,
                              input int k, input int x);
    vec_t v;
    v.id_rs1 = 5'(a); v.id_rs2 = 5'(b); v.idex_rs1 = 5'(c); v.idex_rs2 = 5'(d);
    v.idex_rd = 5'(e); v.memread = 1'(f); v.exmem_rd = 5'(g); v.exmem_rw = 1'(h);
    v.memwb_rd = 5'(i); v.memwb_rw = 1'(j); v.br = 1'(k); v.exp = 8'(x);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0; idex_rd = 0; idex_memread = 0;
    exmem_rd = 0; exmem_regwrite = 0; memwb_rd = 0; memwb_regwrite = 0;
    ex_branch_taken = 0; cnt_clr = 0;
  endtask

  task automatic apply_vec(input vec_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; idex_rs1 = v.idex_rs1; idex_rs2 = v.idex_rs2;
    idex_rd = v.idex_rd; idex_memread = v.memread;
    exmem_rd = v.exmem_rd; exmem_regwrite = v.exmem_rw;
    memwb_rd = v.memwb_rd; memwb_regwrite = v.memwb_rw;
    ex_branch_taken = v.br;
  endtask

  task automatic do_reset();
    @(negedge clk); clear_inputs(); reset = 1;
    @(negedge clk); reset = 0;
  endtask

  // lw x5 in EX, ID reads x5 as rs1
  task automatic set_hazard();
    id_rs1 = 5; idex_rd = 5; idex_memread = 1;
  endtask

  initial begin
    // table: id_rs1,id_rs2,idex_rs1,idex_rs2,idex_rd,memrd,exmem_rd,exmem_rw,memwb_rd,memwb_rw,br,exp
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hC0);  // idle
    vecs[1]  = mk(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 'h10);  // load-use on rs1
    vecs[2]  = mk(3, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0, 'h10);  // load-use on rs2
    vecs[3]  = mk(5, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 'hC0);  // not a load
    vecs[4]  = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 'hC0);  // x0 load / x0 writer
    vecs[5]  = mk(0, 0, 7, 0, 0, 0, 7, 1, 7, 1, 0, 'hC8);  // EX/MEM wins
    vecs[6]  = mk(0, 0, 7, 0, 0, 0, 7, 0, 7, 1, 0, 'hC4);  // MEM/WB only
    vecs[7]  = mk(0, 0, 7, 7, 0, 0, 7, 1, 7, 1, 0, 'hCA);  // both operands EX/MEM
    vecs[8]  = mk(0, 0, 4, 3, 0, 0, 3, 1, 4, 1, 0, 'hC6);  // A from WB, B from MEM
    vecs[9]  = mk(0, 0, 4, 0, 0, 0, 3, 0, 4, 0, 0, 'hC0);  // no regwrite, no forward
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hF0);  // flush
    vecs[11] = mk(5, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 'hF0);  // flush beats stall
    vecs[12] = mk(6, 7, 0, 0, 5, 1, 0, 0, 0, 0, 0, 'hC0);  // load, no dependency

    clear_inputs();
    reset = 1;
    set_hazard(); exmem_rd = 5; exmem_regwrite = 1; idex_rs1 = 5;
    #2;
    check("reset_outputs_u3", {pc3, ifw3, fl3, bub3, fa3, fb3}, 8'hC0);
    check("reset_counters_u3", {sc3, fc3}, 32'h0);
    check("reset_outputs_u1", {pc1, ifw1, fl1, bub1, fa1, fb1}, 8'hC0);
    @(negedge clk); clear_inputs(); reset = 0;

    // table-driven combinational checks on u1 (single-cycle stall)
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      apply_vec(vecs[i]);
      #1;
      check($sformatf("vec%0d_outputs", i), {pc1, ifw1, fl1, bub1, fa1, fb1}, vecs[i].exp);
    end
    @(negedge clk); clear_inputs(); #1;
    check("table_stall_count_u1", sc1, 2);
    check("table_flush_count_u1", fc1, 2);

    // single vs three-cycle load stall; EX gets a bubble after the first cycle
    do_reset();
    @(negedge clk); set_hazard(); #1;
    check("lsc_c0_u3", {pc3, ifw3, bub3}, 3'b001);
    check("lsc_c0_u1", {pc1, ifw1, bub1}, 3'b001);
    @(negedge clk); idex_memread = 0; #1;
    check("lsc_c1_u3_pc", pc3, 0);
    check("lsc_c1_u1_pc", pc1, 1);
    @(negedge clk); #1;
    check("lsc_c2_u3_pc", pc3, 0);
    @(negedge clk); #1;
    check("lsc_c3_u3_pc", pc3, 1);
    check("lsc_stall_count_u3", sc3, 3);
    check("lsc_stall_count_u1", sc1, 1);

    // reset raised while u3 is in STALL
    do_reset();
    @(negedge clk); set_hazard(); exmem_rd = 5; exmem_regwrite = 1; idex_rs1 = 5;
    @(negedge clk); reset = 1; #1;
    check("rst_mid_stall_outputs", {pc3, ifw3, fl3, bub3, fa3}, 6'b110000);
    check("rst_mid_stall_counters", {sc3, fc3}, 32'h0);
    @(negedge clk); reset = 0; clear_inputs(); #1;
    check("rst_mid_stall_after_c0", pc3, 1);
    @(negedge clk); #1;
    check("rst_mid_stall_after_c1", pc3, 1);
    check("rst_mid_stall_count", sc3, 0);

    // taken branch coincident with a load-use hazard in RUN
    do_reset();
    @(negedge clk); set_hazard(); ex_branch_taken = 1; #1;
    check("flush_hz_outputs", {pc3, ifw3, fl3, bub3}, 4'b1111);
    @(negedge clk); clear_inputs(); #1;
    check("flush_hz_next_pc", pc3, 1);
    check("flush_hz_flush_count", fc3, 1);
    check("flush_hz_stall_count", sc3, 0);

    // taken branch arriving while u3 is in STALL
    do_reset();
    @(negedge clk); set_hazard();
    @(negedge clk); idex_memread = 0; ex_branch_taken = 1; #1;
    check("flush_in_stall_outputs", {pc3, ifw3, fl3, bub3}, 4'b1111);
    @(negedge clk); clear_inputs(); #1;
    check("flush_in_stall_next_pc", pc3, 1);
    check("flush_in_stall_counts", {sc3, fc3}, {16'd1, 16'd1});

    // cnt_clr beats a same-cycle increment
    do_reset();
    @(negedge clk); set_hazard(); cnt_clr = 1;
    @(negedge clk); cnt_clr = 0; #1;
    check("clr_beats_inc_u1", sc1, 0);
    @(negedge clk); clear_inputs(); #1;
    check("inc_after_clr_u1", sc1, 1);

    // saturation of the 4-bit stall counter
    @(negedge clk); set_hazard();
    repeat (20) @(negedge clk);
    #1;
    check("stall_count_saturates_u1", sc1, 15);
    clear_inputs(); cnt_clr = 1;
    @(negedge clk); cnt_clr = 0; #1;
    check("clr_after_saturation_u1", sc1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
